hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and scheduling controller for the five-stage pipelined MIPS core. It drives the select lines of the execute-stage forwarding 3:1 muxes and the decode-stage branch-compare 2:1 muxes. It generates the fetch/decode stalls and the decode/execute flushes. It also sequences the multi-cycle multiply/divide unit through a small FSM, so that HI/LO consumers and new mult/div ops wait until the result is written.

## Interface
Parameters:
- MULT_LAT, 4, multiply latency in cycles (1..63)
- DIV_LAT, 32, divide latency in cycles (1..63)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- rsD, rtD  in  5  decode-stage source registers
- rsE, rtE  in  5  execute-stage source registers
- writeregE, writeregM, writeregW  in  5  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1  register-write enables
- memtoregE, memtoregM  in  1  load in E / M
- branchD  in  1  branch in decode
- pcsrcD  in  1  branch taken or jump resolved in decode
- mdReqD  in  1  decode instruction is mult/div/mfhi/mflo/mthi/mtlo
- mdStartE  in  1  mult/div issuing in execute
- mdDivE  in  1  1 = divide, 0 = multiply (valid with mdStartE)
- forwardAE, forwardBE  out  2  E mux select: 00 regfile, 01 WB result, 10 MEM ALU result
- forwardAD, forwardBD  out  1  D branch-compare mux select: 1 = MEM ALU result
- stallF, stallD  out  1  hold PC / IF-ID register
- flushD, flushE  out  1  clear IF-ID / ID-EX register
- mdBusy  out  1  FSM not IDLE
- mdDone  out  1  one-cycle HI/LO write strobe
- stallCnt, flushCnt  out  16  performance counters (see Configuration)

## Operation
- forwardAE = 10 if rsE≠0, regwriteM, and writeregM==rsE; else 01 if rsE≠0, regwriteW, and writeregW==rsE; else 00. MEM has priority over WB. forwardBE is identical using rtE.
- forwardAD = rsD≠0 and regwriteM and writeregM==rsD. forwardBD is identical using rtD.
- lwstall = memtoregE and (rtE==rsD or rtE==rtD).
- branchstall = branchD and one of the following:
  - regwriteE, and writeregE ∈ {rsD, rtD}
  - memtoregM, and writeregM ∈ {rsD, rtD}
- mdstall = mdReqD and (state≠IDLE or mdStartE).
- stallF = stallD = flushE = lwstall | branchstall | mdstall.
- flushD = pcsrcD & ~stallD. When a stall and a taken branch coincide, the stall wins and the branch re-resolves next cycle.
- MDU FSM, with a 6-bit down-counter cnt:
  - IDLE: on mdStartE, load cnt = (mdDivE ? DIV_LAT : MULT_LAT) − 1 and go to BUSY.
  - BUSY: if cnt==0 go to DONE, else cnt−1.
  - DONE: assert mdDone. Go to BUSY (reloading cnt) if mdStartE, else IDLE.
  - mdStartE while in BUSY is ignored. It cannot occur legally because mdstall blocks it.
- mdBusy = (state≠IDLE). mdDone = (state==DONE).

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current FSM state, with no added latency.
- With mdStartE at cycle T:
  - BUSY runs for cycles T+1 .. T+LAT.
  - DONE is at T+LAT+1.
  - The first non-stalled HI/LO consumer in D is at T+LAT+2.
- With LAT=1: one BUSY cycle, then DONE.
- Reset (async, rst_n low):
  - state=IDLE, cnt=0, mdBusy=0, mdDone=0, stallCnt=0, flushCnt=0.
  - The combinational outputs follow the inputs with state=IDLE.
- Reset asserted mid-operation aborts the mult/div: no mdDone is issued.

## Configuration
- HAZARD_PERF_EN defined:
  - stallCnt counts the cycles with stallD=1.
  - flushCnt counts the cycles with flushD=1.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0.
- HAZARD_PERF_EN undefined: stallCnt and flushCnt are constant 0 and no counter registers are built.

## Test plan
- Forwarding:
  - Stimulus: rsE=rtE=5, regwriteM=1, writeregM=5, regwriteW=1, writeregW=5 → required: forwardAE=forwardBE=10.
  - Then regwriteM=0 → required: forwardAE=forwardBE=01.
  - Then rsE=rtE=0 → required: forwardAE=forwardBE=00.
- Load-use: memtoregE=1, rtE=8, rsD=8 → required: stallF=stallD=flushE=1 for exactly that cycle.
  - Add pcsrcD=1 in the same cycle → required: flushD=0.
- Branch hazard: branchD=1, rsD=3, regwriteE=1, writeregE=3 → required: stall.
  - Next cycle, the same value is in M with memtoregM=0 → required: no stall, forwardAD=1.
- Multiply: MULT_LAT=4, mdStartE=1 at T, mdReqD=1 held →
  - required: mdBusy=1 for T+1..T+5, mdDone=1 at T+5, stallD=1 for T..T+5, stallD=0 at T+6.
- Back-to-back divide: DIV_LAT=32, mdStartE=1 in the DONE cycle → required: BUSY is re-entered, and the next mdDone is 33 cycles later.
  - rst_n pulsed low mid-BUSY → required: immediate IDLE, mdBusy=0, no mdDone.
- With HAZARD_PERF_EN: hold stallD active for 70000 cycles → required: stallCnt=0xFFFF.
  - Without the macro → required: stallCnt stays 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and scheduling controller for the five-stage MIPS core.
// Drives the E-stage forwarding selects and the D-stage branch-compare
// selects. Generates the fetch/decode stalls and the decode/execute flushes.
// Sequences the multi-cycle multiply/divide unit.
// Optional build macro: HAZARD_PERF_EN adds saturating 16-bit stall and flush
// cycle counters. Without it, stallCnt and flushCnt are tied to zero.
module hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       pcsrcD,
  input  logic       mdReqD,
  input  logic       mdStartE,
  input  logic       mdDivE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       mdBusy,
  output logic       mdDone,
  output logic [15:0] stallCnt,
  output logic [15:0] flushCnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;

  // The counter holds LAT-1 on BUSY entry, so BUSY lasts exactly LAT cycles.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_LAT - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_LAT - 1);

  md_state_t  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic lwstall, branchstall, mdstall, stall;

  // Forwarding selects: MEM result beats WB result, and r0 is never forwarded.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rsE != 5'd0 && regwriteM && writeregM == rsE)      forwardAE = 2'b10;
    else if (rsE != 5'd0 && regwriteW && writeregW == rsE) forwardAE = 2'b01;
    if (rtE != 5'd0 && regwriteM && writeregM == rtE)      forwardBE = 2'b10;
    else if (rtE != 5'd0 && regwriteW && writeregW == rtE) forwardBE = 2'b01;
    forwardAD = (rsD != 5'd0) && regwriteM && (writeregM == rsD);
    forwardBD = (rtD != 5'd0) && regwriteM && (writeregM == rtD);
  end

  // Stall/flush: a stall freezes F/D and bubbles E. A stalled taken branch
  // re-resolves on the next cycle, so it must not flush D now.
  always_comb begin
    lwstall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
    branchstall = branchD &&
                  ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                   (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
    mdstall     = mdReqD && ((state_q != IDLE) || mdStartE);
    stall       = lwstall | branchstall | mdstall;
    stallF      = stall;
    stallD      = stall;
    flushE      = stall;
    flushD      = pcsrcD & ~stall;
  end

  // MDU state register and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MDU next state: a start from IDLE or DONE loads the latency. A start
  // seen while BUSY is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mdStartE) begin
          state_d = BUSY;
          cnt_d   = mdDivE ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 6'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      DONE: begin
        if (mdStartE) begin
          state_d = BUSY;
          cnt_d   = mdDivE ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // MDU outputs: DONE is the single-cycle HI/LO write strobe.
  always_comb begin
    mdBusy = (state_q != IDLE);
    mdDone = (state_q == DONE);
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating cycle counters for stalls and D-stage flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF)  stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flushD && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`else
  assign stallCnt = 16'd0;
  assign flushCnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus,
// all checked every cycle against a cycle-number based behavioural model.
module tb_hazard_ctrl;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic branchD, pcsrcD, mdReqD, mdStartE, mdDivE;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD, stallF, stallD, flushD, flushE, mdBusy, mdDone;
  logic [15:0] stallCnt, flushCnt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .pcsrcD(pcsrcD),
    .mdReqD(mdReqD), .mdStartE(mdStartE), .mdDivE(mdDivE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .mdBusy(mdBusy), .mdDone(mdDone),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The MDU is modelled by the absolute cycle number at which its result is
  // written: busy while cyc <= done_at, done strobe when cyc == done_at.
  longint cyc = 0;
  longint m_done_at = -1;
  int m_scnt = 0;
  int m_fcnt = 0;

  typedef struct packed {
    logic [1:0] fae, fbe;
    logic fad, fbd, stall, flushD, busy, done;
    logic [15:0] scnt, fcnt;
  } exp_t;

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    if (r != 0 && regwriteM && writeregM == r) return 2'd2;
    if (r != 0 && regwriteW && writeregW == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    logic ld, br, md, active;
    active = (m_done_at >= cyc);
    e.fae = fwd_sel(rsE);
    e.fbe = fwd_sel(rtE);
    e.fad = (rsD != 0) && regwriteM && (writeregM == rsD);
    e.fbd = (rtD != 0) && regwriteM && (writeregM == rtD);
    ld = memtoregE && (rtE == rsD || rtE == rtD);
    br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                     (memtoregM && (writeregM == rsD || writeregM == rtD)));
    md = mdReqD && (active || mdStartE);
    e.stall  = ld | br | md;
    e.flushD = pcsrcD && !e.stall;
    e.busy   = active;
    e.done   = (m_done_at == cyc);
    e.scnt   = 16'(m_scnt);
    e.fcnt   = 16'(m_fcnt);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_done_at = -1;
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      e = model_outputs();
`ifdef HAZARD_PERF_EN
      if (e.stall && m_scnt < 65535) m_scnt++;
      if (e.flushD && m_fcnt < 65535) m_fcnt++;
`endif
      if (m_done_at <= cyc && mdStartE)
        m_done_at = cyc + (mdDivE ? DIV_LAT : MULT_LAT) + 1;
      cyc++;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    exp_t e;
    e = model_outputs();
    check("m_forwardAE", {30'd0, forwardAE}, {30'd0, e.fae});
    check("m_forwardBE", {30'd0, forwardBE}, {30'd0, e.fbe});
    check("m_forwardAD", {31'd0, forwardAD}, {31'd0, e.fad});
    check("m_forwardBD", {31'd0, forwardBD}, {31'd0, e.fbd});
    check("m_stallF", {31'd0, stallF}, {31'd0, e.stall});
    check("m_stallD", {31'd0, stallD}, {31'd0, e.stall});
    check("m_flushE", {31'd0, flushE}, {31'd0, e.stall});
    check("m_flushD", {31'd0, flushD}, {31'd0, e.flushD});
    check("m_mdBusy", {31'd0, mdBusy}, {31'd0, e.busy});
    check("m_mdDone", {31'd0, mdDone}, {31'd0, e.done});
    check("m_stallCnt", {16'd0, stallCnt}, {16'd0, e.scnt});
    check("m_flushCnt", {16'd0, flushCnt}, {16'd0, e.fcnt});
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; branchD = 0; pcsrcD = 0;
    mdReqD = 0; mdStartE = 0; mdDivE = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
    rsE = 5'($urandom_range(0, 7)); rtE = 5'($urandom_range(0, 7));
    writeregE = 5'($urandom_range(0, 7));
    writeregM = 5'($urandom_range(0, 7));
    writeregW = 5'($urandom_range(0, 7));
    regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
    memtoregE = ($urandom_range(0, 3) == 0);
    memtoregM = ($urandom_range(0, 3) == 0);
    branchD = 1'($urandom); pcsrcD = 1'($urandom);
    mdReqD = ($urandom_range(0, 3) == 0);
    mdStartE = ($urandom_range(0, 7) == 0);
    mdDivE = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mdBusy", {31'd0, mdBusy}, 32'd0);
    check("rst_mdDone", {31'd0, mdDone}, 32'd0);
    check("rst_stallCnt", {16'd0, stallCnt}, 32'd0);
    check("rst_flushCnt", {16'd0, flushCnt}, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Forwarding priority
    rsE = 5; rtE = 5; regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5;
    @(negedge clk);
    check("fwd_mem_A", {30'd0, forwardAE}, 32'd2);
    check("fwd_mem_B", {30'd0, forwardBE}, 32'd2);
    next_cycle(); regwriteM = 0;
    @(negedge clk);
    check("fwd_wb_A", {30'd0, forwardAE}, 32'd1);
    check("fwd_wb_B", {30'd0, forwardBE}, 32'd1);
    next_cycle(); rsE = 0; rtE = 0;
    @(negedge clk);
    check("fwd_r0_A", {30'd0, forwardAE}, 32'd0);
    check("fwd_r0_B", {30'd0, forwardBE}, 32'd0);

    // Load-use with a coincident taken branch
    next_cycle(); clear_inputs(); memtoregE = 1; rtE = 8; rsD = 8; pcsrcD = 1;
    @(negedge clk);
    check("lw_stallF", {31'd0, stallF}, 32'd1);
    check("lw_stallD", {31'd0, stallD}, 32'd1);
    check("lw_flushE", {31'd0, flushE}, 32'd1);
    check("lw_flushD", {31'd0, flushD}, 32'd0);
    next_cycle(); memtoregE = 0;
    @(negedge clk);
    check("lw_release", {31'd0, stallD}, 32'd0);
    check("br_flushD", {31'd0, flushD}, 32'd1);

    // Branch hazard, then value in M as ALU result
    next_cycle(); clear_inputs(); branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
    @(negedge clk);
    check("br_stall", {31'd0, stallD}, 32'd1);
    next_cycle(); regwriteE = 0; regwriteM = 1; writeregM = 3; memtoregM = 0;
    @(negedge clk);
    check("br_nostall", {31'd0, stallD}, 32'd0);
    check("br_fwdAD", {31'd0, forwardAD}, 32'd1);

    // Multiply: start at T with consumer held in D
    next_cycle(); clear_inputs(); mdStartE = 1; mdDivE = 0; mdReqD = 1;
    @(negedge clk);
    check("mul_T_stall", {31'd0, stallD}, 32'd1);
    check("mul_T_busy", {31'd0, mdBusy}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      next_cycle(); mdStartE = 0;
      @(negedge clk);
      check("mul_busy", {31'd0, mdBusy}, (k <= 5) ? 32'd1 : 32'd0);
      check("mul_done", {31'd0, mdDone}, (k == 5) ? 32'd1 : 32'd0);
      check("mul_stall", {31'd0, stallD}, (k <= 5) ? 32'd1 : 32'd0);
    end

    // Back-to-back divide, then reset mid-BUSY
    next_cycle(); clear_inputs(); mdStartE = 1; mdDivE = 1;
    for (int k = 1; k <= 76; k++) begin
      next_cycle();
      mdStartE = (k == 33 || k == 66);
      if (k == 76) rst_n = 1'b0;
      @(negedge clk);
      if (k < 76) begin
        check("div_busy", {31'd0, mdBusy}, 32'd1);
        check("div_done", {31'd0, mdDone}, (k == 33 || k == 66) ? 32'd1 : 32'd0);
      end else begin
        check("div_rst_busy", {31'd0, mdBusy}, 32'd0);
        check("div_rst_done", {31'd0, mdDone}, 32'd0);
      end
    end
    next_cycle(); rst_n = 1'b1; mdStartE = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("abort_nodone", {31'd0, mdDone}, 32'd0);
      check("abort_idle", {31'd0, mdBusy}, 32'd0);
      next_cycle();
    end

    // Random traffic, occasional async reset pulses
    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      rand_inputs();
      rst_n = ($urandom_range(0, 199) != 0);
    end
    next_cycle(); rst_n = 1'b1; clear_inputs();

    // Performance counter saturation
    memtoregE = 1; rtE = 1; rsD = 1;
`ifdef HAZARD_PERF_EN
    repeat (70000) next_cycle();
    @(negedge clk);
    check("perf_sat", {16'd0, stallCnt}, 32'h0000FFFF);
`else
    repeat (100) next_cycle();
    @(negedge clk);
    check("perf_off", {16'd0, stallCnt}, 32'd0);
`endif
    next_cycle(); clear_inputs();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
